// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32 execute-stage ALU.
// Operation codes match the opSel field driven by the decoder.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        ADD   = 5'd0,
        SUB   = 5'd1,
        AND   = 5'd2,
        OR    = 5'd3,
        XOR   = 5'd4,
        SLL   = 5'd5,
        SRL   = 5'd6,
        SRA   = 5'd7,
        SLT   = 5'd8,
        SLTU  = 5'd9,
        PASSB = 5'd10
    } alu_op_e;

endpackage

// File: rtl/rv_alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA.
// Only the low log2(XLEN) bits of the shift amount are used.
module rv_alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = alu_pkg::XLEN
) (
    input  logic [XLEN-1:0]         op1,
    input  logic [$clog2(XLEN)-1:0] shamt,
    input  alu_op_e                 op,
    output logic [XLEN-1:0]         shifted
);

    always_comb begin
        shifted = '0;
        case (op)
            SLL:     shifted = op1 << shamt;
            SRL:     shifted = op1 >> shamt;
            SRA:     shifted = $signed(op1) >>> shamt;
            default: shifted = '0;
        endcase
    end

endmodule

// File: rtl/rv_alu.sv
// RV32 integer ALU: combinational result/zero plus a registered copy
// (result_q/zero_q/out_valid) for the EX/MEM pipeline boundary.
module rv_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      opSel,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            in_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q,
    output logic            out_valid
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_op_e         op;
    logic [XLEN-1:0] shifted;

    assign op = alu_op_e'(opSel);

    rv_alu_shifter #(
        .XLEN(XLEN)
    ) u_shifter (
        .op1    (op1),
        .shamt  (op2[SHW-1:0]),
        .op     (op),
        .shifted(shifted)
    );

    // Reserved opSel codes (11..31) fall through to the zero default.
    always_comb begin
        result = '0;
        case (op)
            ADD:           result = op1 + op2;
            SUB:           result = op1 - op2;
            AND:           result = op1 & op2;
            OR:            result = op1 | op2;
            XOR:           result = op1 ^ op2;
            SLL, SRL, SRA: result = shifted;
            SLT:           result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            SLTU:          result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            PASSB:         result = op2;
            default:       result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result_q <= result;
                zero_q   <= zero;
            end
        end
    end

endmodule

// File: tb/tb_rv_alu.sv
// Scoreboard bench for rv_alu: directed vectors plus random ops checked
// against a behavioural reference model, and an asynchronous reset test.
module tb_rv_alu;

    logic        clk;
    logic        rst_n;
    logic [4:0]  opSel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        in_valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        v;
    } stim_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
    } comb_t;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        z;
    } reg_t;

    stim_t stim_q[$];
    comb_t comb_q[$];
    reg_t  reg_q[$];

    rv_alu #(
        .XLEN(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opSel    (opSel),
        .op1      (op1),
        .op2      (op2),
        .in_valid (in_valid),
        .result   (result),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model written from the instruction semantics.
    function automatic logic [31:0] ref_alu(input int unsigned op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        int          sa;
        int          sb;
        sh = int'(b & 32'h1F);
        sa = a;
        sb = b;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            8:  return (sa < sb) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic add_stim(input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                            input logic v);
        stim_t s;
        s.op = op[4:0];
        s.a  = a;
        s.b  = b;
        s.v  = v;
        stim_q.push_back(s);
    endtask

    task automatic set_in(input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                          input logic v);
        opSel    = op[4:0];
        op1      = a;
        op2      = b;
        in_valid = v;
    endtask

    int n_items;
    logic [31:0] held_res;
    logic        held_z;

    initial begin
        rst_n = 1'b0;
        set_in(0, 32'd0, 32'd0, 1'b0);
        #12;
        chk("reset_result_q", result_q, 32'd0);
        chk("reset_zero_q", {31'd0, zero_q}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed combinational vectors with fixed expected values.
        set_in(0, 32'h5, 32'h3, 1'b0);  #1 chk("t1_add", result, 32'd8);
        set_in(1, 32'h5, 32'h3, 1'b0);  #1 chk("t1_sub", result, 32'd2);
        set_in(11, 32'h5, 32'h3, 1'b0); #1 chk("t1_rsv11", result, 32'd0);
        set_in(0, 32'hFFFF_FFFF, 32'h1, 1'b0); #1 chk("t2_add", result, 32'd0);
        chk("t2_zero", {31'd0, zero}, 32'd1);
        set_in(9, 32'hFFFF_FFFF, 32'h1, 1'b0); #1 chk("t2_sltu", result, 32'd0);
        set_in(8, 32'hFFFF_FFFF, 32'h1, 1'b0); #1 chk("t2_slt", result, 32'd1);
        set_in(6, 32'h8000_0000, 32'h24, 1'b0); #1 chk("t3_srl", result, 32'h0800_0000);
        set_in(7, 32'h8000_0000, 32'h24, 1'b0); #1 chk("t3_sra", result, 32'hF800_0000);
        set_in(10, 32'h1234_5678, 32'hABCD_E000, 1'b0); #1 chk("passb", result, 32'hABCD_E000);
        set_in(31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); #1 chk("rsv31", result, 32'd0);

        // Scoreboard stream: capture/hold sequence first, then random ops.
        add_stim(0, 32'h5, 32'h3, 1'b1);
        add_stim(0, 32'h5, 32'h3, 1'b0);
        add_stim(4, 32'h5, 32'h3, 1'b0);
        add_stim(1, 32'h7, 32'h7, 1'b1);
        add_stim(7, 32'h8000_0000, 32'h24, 1'b1);
        add_stim(8, 32'h8000_0000, 32'h1, 1'b1);
        add_stim(9, 32'h8000_0000, 32'h1, 1'b1);
        add_stim(5, 32'h1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 40);
            add_stim($urandom_range(0, 31), a, b, ($urandom_range(0, 3) != 0));
        end
        n_items  = stim_q.size();
        held_res = 32'd0;
        held_z   = 1'b0;

        @(posedge clk);
        #1;
        fork
            begin : driver
                for (int i = 0; i < n_items; i++) begin
                    stim_t s;
                    comb_t c;
                    reg_t  r;
                    @(negedge clk);
                    s = stim_q.pop_front();
                    set_in(s.op, s.a, s.b, s.v);
                    c.res = ref_alu(s.op, s.a, s.b);
                    c.z   = (c.res == 32'd0);
                    comb_q.push_back(c);
                    if (s.v) begin
                        held_res = c.res;
                        held_z   = c.z;
                    end
                    r.v   = s.v;
                    r.res = held_res;
                    r.z   = held_z;
                    reg_q.push_back(r);
                end
            end
            begin : comb_mon
                for (int i = 0; i < n_items; i++) begin
                    comb_t c;
                    @(negedge clk);
                    #2;
                    if (comb_q.size() == 0) begin
                        chk("comb_q_empty", 32'd0, 32'd1);
                    end else begin
                        c = comb_q.pop_front();
                        chk("result", result, c.res);
                        chk("zero", {31'd0, zero}, {31'd0, c.z});
                    end
                end
            end
            begin : reg_mon
                for (int i = 0; i < n_items; i++) begin
                    reg_t r;
                    @(posedge clk);
                    #1;
                    if (reg_q.size() == 0) begin
                        chk("reg_q_empty", 32'd0, 32'd1);
                    end else begin
                        r = reg_q.pop_front();
                        chk("out_valid", {31'd0, out_valid}, {31'd0, r.v});
                        chk("result_q", result_q, r.res);
                        chk("zero_q", {31'd0, zero_q}, {31'd0, r.z});
                    end
                end
            end
        join

        // Asynchronous reset between clock edges.
        @(negedge clk);
        set_in(1, 32'h7, 32'h7, 1'b1);
        @(posedge clk);
        #1 chk("pre_rst_zero_q", {31'd0, zero_q}, 32'd1);
        @(negedge clk);
        set_in(0, 32'h5, 32'h3, 1'b1);
        @(posedge clk);
        #1 chk("pre_rst_result_q", result_q, 32'd8);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_result_q", result_q, 32'd0);
        chk("rst_zero_q", {31'd0, zero_q}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_comb_result", result, 32'd8);
        @(posedge clk);
        #1 chk("rst_hold_result_q", result_q, 32'd0);
        chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        set_in(1, 32'h5, 32'h3, 1'b1);
        #1 chk("rst_comb_sub", result, 32'd2);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_result_q", result_q, 32'd2);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
